// File: rtl/vrased_pkg.sv
// vrased_pkg: shared types and constants for the VRASED reset sequencer.
// State encoding, violation cause bit positions and parameter defaults.
package vrased_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_WAIT_PC
  } state_t;

  localparam int CAUSE_XSTACK     = 0;
  localparam int CAUSE_AC         = 1;
  localparam int CAUSE_ATOMIC     = 2;
  localparam int CAUSE_DMA_AC     = 3;
  localparam int CAUSE_DMA_DETECT = 4;
  localparam int CAUSE_DMA_XSTACK = 5;

  localparam int NUM_SRC_DEF        = 6;
  localparam int HOLD_CYCLES_DEF    = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/vrased_sat_cnt.sv
// vrased_sat_cnt: W-bit saturating up-counter.
// Synchronous clear has priority over increment; holds at all-ones.
module vrased_sat_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // count up on i_inc, stop at the maximum value
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/vrased_reset_seq.sv
// vrased_reset_seq: turns monitor violations into a min-width PUC reset.
// Optional WAIT_PC timeout enabled by defining VRASED_RST_TIMEOUT_EN.
module vrased_reset_seq
  import vrased_pkg::*;
#(
  parameter int          HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter logic [15:0] RESET_HANDLER  = 16'h0000,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int          NUM_SRC        = NUM_SRC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] viol,
  input  logic [15:0]        pc,
  input  logic               cause_clr,
  output logic               reset_out,
  output logic [NUM_SRC-1:0] cause,
  output logic [7:0]         viol_cnt,
  output logic               timeout_flag,
  output logic               busy
);

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);

  state_t             r_state;
  logic [7:0]         r_hold;
  logic               r_reset_out;
  logic               r_busy;
  logic [NUM_SRC-1:0] r_cause;

  logic w_any;
  logic w_hit;
  logic w_tmo;
  logic w_event;
  logic w_in_wait;

  assign w_any     = |viol;
  assign w_hit     = (pc == RESET_HANDLER);
  assign w_in_wait = (r_state == ST_WAIT_PC);

  // a new event is a violation outside ASSERT, or a timeout
  assign w_event = (w_any && (r_state != ST_ASSERT)) || w_tmo;

  // sequencer state, hold counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_reset_out <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state     <= ST_ASSERT;
            r_hold      <= HOLD_LD;
            r_reset_out <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (w_any) begin
            r_hold <= HOLD_LD;
          end else if (r_hold == 8'd0) begin
            r_state     <= ST_WAIT_PC;
            r_reset_out <= 1'b0;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end
        ST_WAIT_PC: begin
          if (w_any || w_tmo) begin
            r_state     <= ST_ASSERT;
            r_hold      <= HOLD_LD;
            r_reset_out <= 1'b1;
          end else if (w_hit) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_reset_out <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // sticky cause; new violation bits win over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cause <= '0;
    end else begin
      r_cause <= (cause_clr ? '0 : r_cause) | viol;
    end
  end

  vrased_sat_cnt #(
    .W(8)
  ) u_viol_cnt (
    .i_clk(clk),
    .i_rst(rst),
    .i_inc(w_event),
    .i_clr(1'b0),
    .o_cnt(viol_cnt)
  );

`ifdef VRASED_RST_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] w_tcnt;
  logic        w_not_wait;
  logic        r_tflag;

  assign w_not_wait = ~w_in_wait;

  // counts WAIT_PC cycles; cleared in every other state
  vrased_sat_cnt #(
    .W(16)
  ) u_tmo_cnt (
    .i_clk(clk),
    .i_rst(rst),
    .i_inc(w_in_wait),
    .i_clr(w_not_wait),
    .o_cnt(w_tcnt)
  );

  assign w_tmo = w_in_wait && !w_any && !w_hit &&
                 (w_tcnt == TMO_LAST);

  // sticky timeout flag; a timeout wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tflag <= 1'b0;
    end else if (w_tmo) begin
      r_tflag <= 1'b1;
    end else if (cause_clr) begin
      r_tflag <= 1'b0;
    end
  end

  assign timeout_flag = r_tflag;
`else
  logic w_unused;
  assign w_unused     = w_in_wait;
  assign w_tmo        = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  assign reset_out = r_reset_out;
  assign busy      = r_busy;
  assign cause     = r_cause;

endmodule

// File: tb/tb_vrased_reset_seq.sv
// tb_vrased_reset_seq: directed bench with a cycle-level reference model.
// Build with VRASED_RST_TIMEOUT_EN to exercise the WAIT_PC timeout.
module tb_vrased_reset_seq;

  localparam int          H   = 4;
  localparam int          T   = 16;
  localparam logic [15:0] RH  = 16'h0000;
  localparam logic [15:0] PCX = 16'hE000;
`ifdef VRASED_RST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  viol = '0;
  logic [15:0] pc = PCX;
  logic        cause_clr = 1'b0;
  logic        reset_out, timeout_flag, busy;
  logic [5:0]  cause;
  logic [7:0]  viol_cnt;

  logic        reset_out1, timeout_flag1, busy1;
  logic [5:0]  cause1;
  logic [7:0]  viol_cnt1;

  always #5 clk = ~clk;

  vrased_reset_seq #(
    .HOLD_CYCLES(H), .RESET_HANDLER(RH),
    .TIMEOUT_CYCLES(T), .NUM_SRC(6)
  ) dut (
    .clk(clk), .rst(rst), .viol(viol), .pc(pc),
    .cause_clr(cause_clr), .reset_out(reset_out),
    .cause(cause), .viol_cnt(viol_cnt),
    .timeout_flag(timeout_flag), .busy(busy)
  );

  vrased_reset_seq #(
    .HOLD_CYCLES(1), .RESET_HANDLER(RH),
    .TIMEOUT_CYCLES(T), .NUM_SRC(6)
  ) dut1 (
    .clk(clk), .rst(rst), .viol(viol), .pc(pc),
    .cause_clr(cause_clr), .reset_out(reset_out1),
    .cause(cause1), .viol_cnt(viol_cnt1),
    .timeout_flag(timeout_flag1), .busy(busy1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int hi = 0;
  int hi1 = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: remaining high cycles, waiting flag, wait age.
  int         m_left = 0;
  bit         m_wait = 0;
  int         m_age  = 0;
  logic [5:0] m_cause = '0;
  int         m_cnt  = 0;
  bit         m_tf   = 0;

  always @(posedge clk) begin
    bit act;
    bit ev;
    if (rst) begin
      m_left = 0; m_wait = 0; m_age = 0;
      m_cause = '0; m_cnt = 0; m_tf = 0;
    end else begin
      act = (m_left > 0);
      ev  = 0;
      if (cause_clr) begin
        m_cause = '0;
        m_tf = 0;
      end
      m_cause = m_cause | viol;
      if (viol != 0) begin
        ev = !act;
        m_left = H;
        m_wait = 0;
      end else if (act) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_wait = 1;
          m_age = 0;
        end
      end else if (m_wait) begin
        if (pc == RH) begin
          m_wait = 0;
        end else if (TMO_EN) begin
          m_age = m_age + 1;
          if (m_age == T) begin
            m_tf = 1; ev = 1;
            m_left = H; m_wait = 0;
          end
        end
      end
      if (ev && m_cnt < 255) m_cnt = m_cnt + 1;
    end
  end

  // cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("reset_out", 32'(reset_out), 32'(m_left > 0));
      chk("busy", 32'(busy), 32'((m_left > 0) || m_wait));
      chk("cause", 32'(cause), 32'(m_cause));
      chk("viol_cnt", 32'(viol_cnt), 32'(m_cnt));
      chk("timeout_flag", 32'(timeout_flag), 32'(m_tf));
    end
  end

  // drive one cycle of inputs; count high reset cycles seen so far
  task automatic step(input logic [5:0] v, input logic [15:0] p,
                      input logic c, input logic r);
    @(negedge clk);
    if (reset_out === 1'b1) hi++;
    if (reset_out1 === 1'b1) hi1++;
    viol = v; pc = p; cause_clr = c; rst = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, PCX, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    step('0, PCX, 1'b0, 1'b1);
    step('0, PCX, 1'b0, 1'b0);
  endtask

  initial begin
    step('0, PCX, 1'b0, 1'b1);
    do_rst();
    chk_en = 1'b1;
    chk("rst reset_out", 32'(reset_out), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst cause", 32'(cause), 32'd0);
    chk("rst viol_cnt", 32'(viol_cnt), 32'd0);

    // isolated atomicity violation
    hi = 0; hi1 = 0;
    step(6'b000100, PCX, 1'b0, 1'b0);
    idle(8);
    chk("s1 high cycles", 32'(hi), 32'd4);
    chk("s1 hold1 high", 32'(hi1), 32'd1);
    chk("s1 waiting", 32'(busy), 32'd1);
    chk("s1 cause", 32'(cause), 32'h04);
    chk("s1 viol_cnt", 32'(viol_cnt), 32'd1);
    step('0, RH, 1'b0, 1'b0);
    step('0, PCX, 1'b0, 1'b0);
    chk("s1 busy drop", 32'(busy), 32'd0);

    // extension by a second violation in the 3rd ASSERT cycle
    do_rst();
    hi = 0; hi1 = 0;
    step(6'b000001, PCX, 1'b0, 1'b0);
    idle(2);
    step(6'b100000, PCX, 1'b0, 1'b0);
    idle(10);
    chk("s2 high cycles", 32'(hi), 32'd7);
    chk("s2 hold1 high", 32'(hi1), 32'd2);
    chk("s2 cause", 32'(cause), 32'h21);
    chk("s2 viol_cnt", 32'(viol_cnt), 32'd1);

    // PC hit and violation together in WAIT_PC: violation wins
    step(6'b000010, RH, 1'b0, 1'b0);
    step('0, PCX, 1'b0, 1'b0);
    chk("s3 reassert", 32'(reset_out), 32'd1);
    chk("s3 viol_cnt", 32'(viol_cnt), 32'd2);
    idle(6);
    step('0, RH, 1'b0, 1'b0);
    idle(1);

    // saturation after 300 events, then clear behaviour
    do_rst();
    for (int e = 0; e < 300; e++) begin
      step(6'b000001, PCX, 1'b0, 1'b0);
      idle(4);
      step('0, RH, 1'b0, 1'b0);
    end
    idle(1);
    chk("s4 saturate", 32'(viol_cnt), 32'd255);
    step('0, PCX, 1'b1, 1'b0);
    idle(1);
    chk("s4 clr only", 32'(cause), 32'd0);
    step(6'b001000, PCX, 1'b1, 1'b0);
    idle(1);
    chk("s4 set wins", 32'(cause), 32'h08);
    chk("s4 still sat", 32'(viol_cnt), 32'd255);
    idle(5);
    step('0, RH, 1'b0, 1'b0);
    idle(1);

    // WAIT_PC with the handler never reached
    do_rst();
    step(6'b010000, PCX, 1'b0, 1'b0);
    idle(5);
    hi = 0;
    idle(17);
    chk("s5 timeout high", 32'(hi != 0), 32'(TMO_EN));
    chk("s5 timeout flag", 32'(timeout_flag), 32'(TMO_EN));
    chk("s5 timeout cnt", 32'(viol_cnt), TMO_EN ? 32'd2 : 32'd1);
    step('0, PCX, 1'b1, 1'b0);
    idle(1);
    chk("s5 flag cleared", 32'(timeout_flag), 32'd0);
    idle(4);
    step('0, RH, 1'b0, 1'b0);
    idle(1);

    // reset in the middle of ASSERT
    step(6'b000001, PCX, 1'b0, 1'b0);
    step('0, PCX, 1'b0, 1'b0);
    step('0, PCX, 1'b0, 1'b1);
    step('0, PCX, 1'b0, 1'b0);
    chk("s6 reset_out", 32'(reset_out), 32'd0);
    chk("s6 busy", 32'(busy), 32'd0);
    chk("s6 cause", 32'(cause), 32'd0);
    chk("s6 viol_cnt", 32'(viol_cnt), 32'd0);
    chk("s6 hold1 out", 32'(reset_out1), 32'd0);
    idle(3);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vrased_reset_seq.md
# vrased_reset_seq

Reset sequencer for the VRASED hardware monitor. Collects the per-monitor violation flags (X_stack, AC, atomicity, dma_AC, dma_detect, dma_X_stack) and turns any violation into a registered, minimum-width reset pulse to the MCU. It then waits for the core to re-enter the reset handler before re-arming. It also keeps a sticky cause register and a saturating violation counter for software and debug readout. It sits between the monitor sub-blocks and the openMSP430 PUC input, replacing the plain OR of monitor resets.

## Interface

Parameters:
- `HOLD_CYCLES`, default 4: number of cycles `reset_out` is held high per violation; legal range 1–255.
- `RESET_HANDLER`, default 16'h0000: PC value that marks a completed reset.
- `TIMEOUT_CYCLES`, default 1024: cycles allowed in WAIT_PC before re-asserting (used only with the timeout feature); 16-bit.
- `NUM_SRC`, default 6: number of violation sources.

Ports:
- `clk`, in, 1: system clock. The block uses one clock.
- `rst`, in, 1: synchronous, active-high reset.
- `viol`, in, NUM_SRC: per-monitor violation flags, level, bit order {dma_X_stack, dma_detect, dma_AC, atomicity, AC, X_stack} (MSB to LSB).
- `pc`, in, 16: current program counter.
- `cause_clr`, in, 1: single-cycle pulse; clears `cause` and `timeout_flag`.
- `reset_out`, out, 1: registered reset request to the PUC.
- `cause`, out, NUM_SRC: sticky OR of all violation sources seen since the last clear.
- `viol_cnt`, out, 8: count of violation events; saturates at 255.
- `timeout_flag`, out, 1: sticky; set on a WAIT_PC timeout (only with the timeout feature, otherwise tied to 0).
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation

- States: IDLE, ASSERT, WAIT_PC. On `rst`: state = IDLE, and `reset_out`, `cause`, `viol_cnt`, `timeout_flag`, `busy` and the hold counter are all 0.
- IDLE:
  - If `|viol`: go to ASSERT, load the hold counter with HOLD_CYCLES-1, OR `viol` into `cause`, and increment `viol_cnt`.
- ASSERT:
  - `reset_out` = 1 and the hold counter decrements each cycle.
  - Any `|viol` in this state reloads the counter to HOLD_CYCLES-1 and ORs into `cause`. It does not increment `viol_cnt`; one event counts as one increment.
  - When the counter is 0 and there is no violation, go to WAIT_PC.
- WAIT_PC:
  - `reset_out` = 0.
  - If `pc == RESET_HANDLER`: go to IDLE.
  - Else if `|viol`: go to ASSERT, handled as a new event (counter reload, cause OR, `viol_cnt` increment).
  - If both conditions hold in the same cycle, the violation wins.
- `cause_clr`:
  - Clears `cause` and `timeout_flag` in any state.
  - If a violation arrives in the same cycle, `cause` takes the new `viol` bits, so set wins over clear for active bits.
- `viol_cnt`: increments by exactly 1 per event and holds at 8'hFF. `cause_clr` does not clear it; only `rst` does.

## Timing

- `viol` sampled high at edge n gives `reset_out` = 1 after edge n (one-cycle latency).
- A single isolated violation gives exactly HOLD_CYCLES consecutive high cycles of `reset_out`.
- A violation during ASSERT extends the pulse to HOLD_CYCLES cycles counted from that violation.
- Leaving WAIT_PC for IDLE happens at the edge where `pc == RESET_HANDLER` is sampled. `busy` drops in the following cycle.
- `rst` asserted mid-sequence aborts the sequence immediately. `reset_out` is low the cycle after, and all state returns to reset values.
- HOLD_CYCLES = 1: ASSERT lasts exactly one cycle.

## Configuration

- `VRASED_RST_TIMEOUT_EN` defined:
  - A 16-bit counter runs in WAIT_PC.
  - If TIMEOUT_CYCLES elapse without `pc == RESET_HANDLER`, the block sets `timeout_flag`, increments `viol_cnt`, and re-enters ASSERT.
  - The counter clears on every WAIT_PC entry.
- Undefined: WAIT_PC waits indefinitely, `timeout_flag` is constant 0, and no timeout counter is synthesized.

## Structure

- Shared package `vrased_pkg` holds:
  - the state enum (IDLE/ASSERT/WAIT_PC);
  - the cause bit index constants (CAUSE_XSTACK=0 … CAUSE_DMA_XSTACK=5);
  - the default HOLD_CYCLES and TIMEOUT_CYCLES values.
- One sub-module, `vrased_sat_cnt`: parameterized-width saturating up-counter with inc/clr. It is instantiated for `viol_cnt` and, under the macro, for the timeout counter.

## Test plan

- Pulse `viol`=6'b000100 for 1 cycle from IDLE, HOLD_CYCLES=4 -> `reset_out` high exactly 4 cycles starting the next cycle; `cause`=6'b000100; `viol_cnt`=1; WAIT_PC until `pc`=16'h0000 -> IDLE.
- `viol`=6'b000001 in IDLE, then `viol`=6'b100000 at the 3rd ASSERT cycle -> pulse extends to 4 cycles after the second violation; `cause`=6'b100001; `viol_cnt`=1.
- In WAIT_PC, apply `pc`=RESET_HANDLER and `viol`=6'b000010 in the same cycle -> back to ASSERT; `viol_cnt`=2.
- Apply 300 separate events -> `viol_cnt` stays at 255; `cause_clr` together with `viol`=6'b001000 -> `cause`=6'b001000.
- With the macro defined and TIMEOUT_CYCLES=16, hold `pc`=16'hE000 in WAIT_PC -> after 16 cycles `timeout_flag`=1 and `reset_out` re-asserts. Without the macro, `reset_out` stays low indefinitely.
- Assert `rst` during ASSERT -> next cycle `reset_out`=0, `busy`=0, `cause`=0, `viol_cnt`=0.
